wrr_vc_arbiter: RTL and testbench

Weighted round-robin arbiter that drains NCH virtual-channel FIFOs into one output stream. It is the parametrised successor of the 4-channel fixed-fallback arbiter. It sits between the virtual-channel FIFO bank (first-word-fall-through heads) and the single downstream link. It issues one-hot pops, grants each channel up to weight+1 consecutive words, rotates fairly past empty channels, and registers the selected word behind a valid/ready handshake.

---
 rtl/wrr_pkg.sv | 18 +
 rtl/wrr_next_sel.sv | 43 ++++
 rtl/wrr_vc_arbiter.sv | 149 ++++++++++++++
 tb/tb_wrr_vc_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/wrr_pkg.sv
// Shared types and constants for the weighted round-robin virtual-channel arbiter.
package wrr_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   localparam logic [63:0] EMPTY = '0;

   localparam int STAT_W = 16;
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
      return (value == STAT_MAX) ? value : value + STAT_W'(1);
   endfunction

endpackage

// File: rtl/wrr_next_sel.sv
// Rotating-priority finder: first set bit of valid at or after start, wrapping NCH-1 -> 0.
module wrr_next_sel #(
   parameter int NCH = 4,
   localparam int IW = $clog2(NCH)
) (
   input  logic [NCH-1:0] valid,
   input  logic [IW-1:0]  start,
   output logic [IW-1:0]  found,
   output logic           any
);

   localparam logic [IW:0] NCH_W = (IW+1)'(NCH);

   logic [NCH-1:0] rot;
   logic [IW-1:0]  off;
   logic [IW:0]    found_sum;
   logic [IW:0]    found_wrap;

   // rot[k] is the validity of the channel k places after start.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_rot
      logic [IW:0] sum;
      logic [IW:0] wrapped;
      assign sum     = {1'b0, start} + (IW+1)'(gi);
      assign wrapped = (sum >= NCH_W) ? sum - NCH_W : sum;
      assign rot[gi] = valid[wrapped[IW-1:0]];
   end

   always_comb begin
      off = '0;
      any = 1'b0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off = IW'(k);
            any = 1'b1;
         end
      end
   end

   assign found_sum  = {1'b0, start} + {1'b0, off};
   assign found_wrap = (found_sum >= NCH_W) ? found_sum - NCH_W : found_sum;
   assign found      = found_wrap[IW-1:0];

endmodule

// File: rtl/wrr_vc_arbiter.sv
// Weighted round-robin arbiter draining NCH virtual-channel FIFOs into one registered stream.
// Optional per-channel saturating grant counters are built when WRR_STATS_EN is defined.
module wrr_vc_arbiter
   import wrr_pkg::*;
#(
   parameter int NCH = 4,
   parameter int DW  = 4,
   parameter int WW  = 3,
   localparam int IW = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enb,
   input  logic [NCH-1:0]    valid_channel,
   input  logic [NCH*DW-1:0] data_in,
   input  logic [NCH*WW-1:0] weight,
   input  logic              out_ready,
   output logic [NCH-1:0]    pop,
   output logic [DW-1:0]     data_out,
   output logic              data_out_valid,
   output logic [IW-1:0]     grant_id
`ifdef WRR_STATS_EN
   ,
   output logic [NCH*STAT_W-1:0] grant_count
`endif
);

   logic [DW-1:0] data_word   [NCH];
   logic [WW-1:0] weight_word [NCH];

   for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign data_word[gi]   = data_in[gi*DW +: DW];
      assign weight_word[gi] = weight[gi*WW +: WW];
   end

   state_t        state_reg, state_next;
   logic [IW-1:0] ptr_reg, ptr_next;
   logic [WW:0]   credit_reg, credit_next;
   logic          fresh_reg, fresh_next;
   logic [DW-1:0] data_reg, data_next;
   logic          dov_reg, dov_next;
   logic [IW-1:0] gid_reg, gid_next;

   logic [IW-1:0] start;
   logic [IW-1:0] found;
   logic          any_valid;
   logic          keep;
   logic          adv;
   logic          grant;
   logic [IW-1:0] sel;

   assign start = (ptr_reg == IW'(NCH - 1)) ? '0 : ptr_reg + IW'(1);

   wrr_next_sel #(
      .NCH (NCH)
   ) u_next_sel (
      .valid (valid_channel),
      .start (start),
      .found (found),
      .any   (any_valid)
   );

   assign adv   = rst && enb && (!dov_reg || out_ready);
   assign grant = adv && any_valid;
   assign keep  = valid_channel[ptr_reg] && (credit_reg != '0);

   // Straight after reset no channel has been served yet, so the lowest valid
   // channel wins instead of the search starting one past ptr.
   always_comb begin
      if (keep)
         sel = ptr_reg;
      else if (fresh_reg && valid_channel[0])
         sel = '0;
      else
         sel = found;
   end

   always_comb begin
      state_next  = state_reg;
      ptr_next    = ptr_reg;
      credit_next = credit_reg;
      fresh_next  = fresh_reg;
      data_next   = data_reg;
      dov_next    = dov_reg;
      gid_next    = gid_reg;
      pop         = '0;

      if (grant) begin
         pop[sel]   = 1'b1;
         data_next  = data_word[sel];
         gid_next   = sel;
         dov_next   = 1'b1;
         fresh_next = 1'b0;
         if (sel == ptr_reg && credit_reg != '0) begin
            credit_next = credit_reg - (WW+1)'(1);
         end else begin
            // Entering (or re-entering) a channel: weight+1 grants, one spent now.
            ptr_next    = sel;
            credit_next = {1'b0, weight_word[sel]};
         end
      end else if (adv) begin
         dov_next = 1'b0;
      end

      case (state_reg)
         IDLE:    if (grant) state_next = SERVE;
         SERVE:   if (adv && !any_valid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg  <= IDLE;
         ptr_reg    <= '0;
         credit_reg <= '0;
         fresh_reg  <= 1'b1;
         data_reg   <= EMPTY[DW-1:0];
         dov_reg    <= 1'b0;
         gid_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         ptr_reg    <= ptr_next;
         credit_reg <= credit_next;
         fresh_reg  <= fresh_next;
         data_reg   <= data_next;
         dov_reg    <= dov_next;
         gid_reg    <= gid_next;
      end
   end

   assign data_out       = data_reg;
   assign data_out_valid = dov_reg;
   assign grant_id       = gid_reg;

`ifdef WRR_STATS_EN
   for (genvar gi = 0; gi < NCH; gi++) begin : g_stats
      logic [STAT_W-1:0] count_reg;
      always_ff @(posedge clk) begin
         if (!rst)
            count_reg <= '0;
         else if (grant && sel == IW'(gi))
            count_reg <= sat_inc(count_reg);
      end
      assign grant_count[gi*STAT_W +: STAT_W] = count_reg;
   end
`endif

endmodule

// File: tb/tb_wrr_vc_arbiter.sv
// Directed self-checking bench for wrr_vc_arbiter (NCH=4, DW=4, WW=3).
module tb_wrr_vc_arbiter;

   logic        clk;
   logic        rst;
   logic        enb;
   logic [3:0]  valid_channel;
   logic [15:0] data_in;
   logic [11:0] weight;
   logic        out_ready;
   logic [3:0]  pop;
   logic [3:0]  data_out;
   logic        data_out_valid;
   logic [1:0]  grant_id;
`ifdef WRR_STATS_EN
   logic [63:0] grant_count;
`endif

   int num_checks = 0;
   int num_errors = 0;

   wrr_vc_arbiter #(
      .NCH (4),
      .DW  (4),
      .WW  (3)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enb            (enb),
      .valid_channel  (valid_channel),
      .data_in        (data_in),
      .weight         (weight),
      .out_ready      (out_ready),
      .pop            (pop),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .grant_id       (grant_id)
`ifdef WRR_STATS_EN
      ,
      .grant_count    (grant_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cycle();
      cycle();
      rst = 1'b1;
   endtask

   // One grant expected to channel id: check the pop before the edge, the registered word after.
   task automatic grant_step(input string tag, input int id);
      logic [3:0] exp_pop;
      logic [3:0] exp_data;
      exp_pop  = 4'b0001 << id;
      exp_data = 4'hA + 4'(id);
      #1;
      check_value({tag, " pop"}, 32'(pop), 32'(exp_pop));
      cycle();
      check_value({tag, " grant_id"}, 32'(grant_id), 32'(id));
      check_value({tag, " data_out"}, 32'(data_out), 32'(exp_data));
      check_value({tag, " valid"}, 32'(data_out_valid), 32'd1);
   endtask

   int seq1 [10] = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1};
   int seq2 [4]  = '{1, 3, 1, 3};

   initial begin
      rst           = 1'b0;
      enb           = 1'b1;
      out_ready     = 1'b1;
      valid_channel = 4'hF;
      data_in       = {4'hD, 4'hC, 4'hB, 4'hA};
      weight        = {3'd0, 3'd2, 3'd1, 3'd0};

      // Reset held with every channel valid: no pop, outputs cleared.
      cycle();
      check_value("reset pop", 32'(pop), 32'd0);
      cycle();
      check_value("reset data_out", 32'(data_out), 32'd0);
      check_value("reset valid", 32'(data_out_valid), 32'd0);
      check_value("reset grant_id", 32'(grant_id), 32'd0);
      rst = 1'b1;

      // Weights {0,1,2,0}, all channels valid.
      for (int i = 0; i < 10; i++) grant_step($sformatf("wrr[%0d]", i), seq1[i]);

      // Only channels 1 and 3 valid, zero weights.
      do_reset();
      weight        = '0;
      valid_channel = 4'b1010;
      for (int i = 0; i < 4; i++) grant_step($sformatf("alt[%0d]", i), seq2[i]);

      // Channel 2 (weight 3) empties mid-turn, then returns for a fresh turn.
      do_reset();
      weight        = {3'd0, 3'd3, 3'd0, 3'd0};
      valid_channel = 4'b1101;
      grant_step("mid a", 0);
      grant_step("mid b", 2);
      grant_step("mid c", 2);
      valid_channel = 4'b1001;
      grant_step("mid d", 3);
      grant_step("mid e", 0);
      valid_channel = 4'b1101;
      for (int i = 0; i < 4; i++) grant_step($sformatf("fresh[%0d]", i), 2);
      grant_step("fresh end", 3);

      // Backpressure: word 4'hA held for three cycles.
      do_reset();
      weight        = '0;
      valid_channel = 4'b0011;
      grant_step("stall first", 0);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_value($sformatf("stall[%0d] pop", i), 32'(pop), 32'd0);
         cycle();
         check_value($sformatf("stall[%0d] data_out", i), 32'(data_out), 32'hA);
         check_value($sformatf("stall[%0d] valid", i), 32'(data_out_valid), 32'd1);
      end
      out_ready = 1'b1;
      grant_step("stall release", 1);

      // Arbitration disabled: everything holds.
      enb = 1'b0;
      #1;
      check_value("enb0 pop", 32'(pop), 32'd0);
      cycle();
      check_value("enb0 data_out", 32'(data_out), 32'hB);
      check_value("enb0 valid", 32'(data_out_valid), 32'd1);
      enb = 1'b1;

      // No valid channel: output drains, grant_id holds.
      valid_channel = 4'b0000;
      #1;
      check_value("empty pop", 32'(pop), 32'd0);
      cycle();
      check_value("empty valid", 32'(data_out_valid), 32'd0);
      check_value("empty grant_id", 32'(grant_id), 32'd1);

      // Reset mid-stream with a word pending.
      valid_channel = 4'b0110;
      grant_step("pre-reset", 2);
      rst = 1'b0;
      #1;
      check_value("rst low pop", 32'(pop), 32'd0);
      cycle();
      check_value("rst data_out", 32'(data_out), 32'd0);
      check_value("rst valid", 32'(data_out_valid), 32'd0);
      check_value("rst grant_id", 32'(grant_id), 32'd0);
      check_value("rst ptr", 32'(dut.ptr_reg), 32'd0);
      rst = 1'b1;
      grant_step("post-reset a", 1);
      grant_step("post-reset b", 2);

`ifdef WRR_STATS_EN
      // Channel 0 alone long enough to saturate its counter.
      do_reset();
      valid_channel = 4'b0001;
      repeat (70000) cycle();
      check_value("stat ch0", 32'(grant_count[15:0]), 32'hFFFF);
      check_value("stat ch1", 32'(grant_count[31:16]), 32'd0);
      check_value("stat ch2", 32'(grant_count[47:32]), 32'd0);
      check_value("stat ch3", 32'(grant_count[63:48]), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
